cpu_sequencer: RTL
==================

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL have clock and reset ports: clock `clk`; reset `rst_n`, asynchronous, active-low.
REQ-002 Ports SHALL be (name  direction  width  meaning):
- `clk`  in  1  sole clock; all state rising-edge.
- `rst_n`  in  1  async active-low reset.
- `start`  in  1  level; leaves IDLE.
- `halt_req`  in  1  stop after the current instruction.
- `imem_req`  out  1  instruction fetch request.
- `imem_addr`  out  8  fetch address; equals pc.
- `imem_ack`  in  1  fetch data valid.
- `imem_rdata`  in  8  instruction byte.
- `neq`  in  1  datapath compare: reg[rd] != reg[rs].
- `rd`, `rs`, `rt`  out  2 each  IR[5:4], IR[3:2], IR[1:0].
- `alu_op`  out  2  IR[7:6].
- `imm`  out  8  sign-extended IR[3:0].
- `bne`  out  1  branch decoded; feeds the register-enable stage.
- `wb_strobe`  out  1  register write strike.
- `busy`  out  1  state != IDLE.
- `pc`  out  8  program counter.
- `insn_cnt`  out  16  retired instructions.

Function
REQ-003 Instruction format SHALL be: opcode IR[7:6] (00 ADD, 01 SUB, 10 LI, 11 BNE); branch offset = sign-extended IR[1:0] (-2..+1).
REQ-004 FSM states SHALL be IDLE, FETCH, DECODE, EXEC, WB, one-hot or binary.
REQ-005 IDLE SHALL go to FETCH on the first edge with `start`=1; otherwise it stays in IDLE.
REQ-006 FETCH SHALL hold `imem_req`=1 and `imem_addr`=pc.
REQ-007 In FETCH, on an edge with `imem_ack`=1 the block SHALL latch `imem_rdata` into IR and go to DECODE; with `imem_ack`=0 it SHALL stay in FETCH with no timeout.
REQ-008 `imem_req` SHALL be 0 in every state other than FETCH; an `imem_ack` outside FETCH SHALL be ignored.
REQ-009 DECODE and EXEC SHALL each last exactly one cycle.
REQ-010 EXEC SHALL register `neq` into a taken flag when opcode=11; for other opcodes the flag SHALL be 0.
REQ-011 `wb_strobe` SHALL be 1 only in WB and only for opcodes 00, 01, 10; it SHALL be 0 for BNE.
REQ-012 `bne` SHALL be 1 in DECODE, EXEC and WB when opcode=11; it SHALL be 0 in all other cases, including IDLE and FETCH.
REQ-013 `rd`, `rs`, `rt`, `alu_op` and `imm` SHALL be driven from IR at all times; they SHALL be stable from DECODE through WB.
REQ-014 On the WB edge, pc SHALL update as follows: if taken, pc = pc + 1 + offset; otherwise pc = pc + 1; arithmetic is modulo 256.
- Wrap: 0xFF+1 -> 0x00; 0x00+1-2 -> 0xFF.
REQ-015 On the WB edge, `insn_cnt` SHALL increment by 1 and saturate at 0xFFFF.
REQ-016 On the WB edge, the next state SHALL be IDLE if `halt_req`=1; otherwise it SHALL be FETCH. `halt_req` in other states SHALL have no effect until WB.
REQ-017 With `halt_req`=1 and `start`=1 in the same WB cycle, halt SHALL win (go to IDLE).
REQ-018 From IDLE, a later `start` SHALL resume from the current pc; pc and `insn_cnt` SHALL be retained.
REQ-019 Latency SHALL be 4 cycles per instruction with zero-wait ack (FETCH, DECODE, EXEC, WB); each cycle of ack wait SHALL add one cycle.

Reset
REQ-020 While `rst_n`=0, asynchronously, the block SHALL force: state=IDLE, pc=0, IR=0, taken=0, `insn_cnt`=0.
- Hence `imem_req`, `bne`, `wb_strobe`, `busy` = 0 and `rd`, `rs`, `rt`, `alu_op`, `imm` = 0.
REQ-021 Reset asserted mid-instruction (any state) SHALL abort it with no `wb_strobe` pulse and no pc update.
REQ-022 After `rst_n` deasserts, the first FETCH SHALL require `start`.

Verification
REQ-023 Reset then `start`=1, zero-wait ack, imem = {0x90 (LI r1,0), 0x15 (ADD r1,r1,r1)} -> `wb_strobe` pulses 4 cycles apart; pc 0->1->2; `insn_cnt`=2.
REQ-024 BNE 0xC7 at pc=5 with `neq`=1 -> pc=5; with `neq`=0 -> pc=6; `bne`=1 in DECODE/EXEC/WB; `wb_strobe` never 1.
REQ-025 `imem_ack` held low 3 cycles in FETCH -> `imem_req` stays 1 and `imem_addr` stable; the instruction completes in 7 cycles.
REQ-026 pc=0xFF, non-branch -> pc=0x00; BNE at pc=0x00, offset -2, `neq`=1 -> pc=0xFF.
REQ-027 `halt_req`=1 during EXEC then deasserted -> no effect; `halt_req`=1 at WB -> IDLE, `busy`=0; `start` resumes at the retained pc.
REQ-028 `rst_n` low in EXEC of an ADD -> no `wb_strobe`; all outputs 0 immediately; pc=0.

Source files
------------

// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: fetches one byte per instruction, decodes
// it onto datapath control lines and retires it with pc/count updates in WB.
module cpu_sequencer (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        halt_req,
   output logic        imem_req,
   output logic [7:0]  imem_addr,
   input  logic        imem_ack,
   input  logic [7:0]  imem_rdata,
   input  logic        neq,
   output logic [1:0]  rd,
   output logic [1:0]  rs,
   output logic [1:0]  rt,
   output logic [1:0]  alu_op,
   output logic [7:0]  imm,
   output logic        bne,
   output logic        wb_strobe,
   output logic        busy,
   output logic [7:0]  pc,
   output logic [15:0] insn_cnt
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_WB     = 3'd4
   } state_t;

   localparam logic [1:0] OP_BNE = 2'b11;

   state_t      r_state;
   state_t      w_next_state;
   logic [7:0]  r_pc;
   logic [7:0]  r_ir;
   logic        r_taken;
   logic [15:0] r_insn_cnt;

   logic        w_ir_load;
   logic        w_is_bne;
   logic        w_exec;
   logic        w_retire;
   logic [7:0]  w_offset;
   logic [7:0]  w_pc_next;
   logic [15:0] w_cnt_next;

   function automatic logic [7:0] sext4(input logic [3:0] v);
      return {{4{v[3]}}, v};
   endfunction

   function automatic logic [7:0] sext2(input logic [1:0] v);
      return {{6{v[1]}}, v};
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      logic [15:0] res;
      if (v == 16'hFFFF) begin
         res = v;
      end else begin
         res = v + 16'd1;
      end
      return res;
   endfunction

   // Next-state decode; halt is only sampled when an instruction retires.
   always_comb begin
      w_next_state = r_state;
      w_ir_load    = 1'b0;
      w_exec       = 1'b0;
      w_retire     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_next_state = ST_FETCH;
            end else begin
               w_next_state = ST_IDLE;
            end
         end
         ST_FETCH: begin
            if (imem_ack) begin
               w_next_state = ST_DECODE;
               w_ir_load    = 1'b1;
            end else begin
               w_next_state = ST_FETCH;
            end
         end
         ST_DECODE: begin
            w_next_state = ST_EXEC;
         end
         ST_EXEC: begin
            w_next_state = ST_WB;
            w_exec       = 1'b1;
         end
         ST_WB: begin
            w_retire = 1'b1;
            if (halt_req) begin
               w_next_state = ST_IDLE;
            end else begin
               w_next_state = ST_FETCH;
            end
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   assign w_is_bne   = (r_ir[7:6] == OP_BNE);
   assign w_offset   = sext2(r_ir[1:0]);
   assign w_cnt_next = sat_inc16(r_insn_cnt);

   // Branch target selection; modulo-256 wrap comes from the 8-bit adder.
   always_comb begin
      w_pc_next = r_pc + 8'd1;
      if (r_taken) begin
         w_pc_next = r_pc + 8'd1 + w_offset;
      end else begin
         w_pc_next = r_pc + 8'd1;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Instruction register and branch-taken flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ir    <= 8'h00;
         r_taken <= 1'b0;
      end else begin
         if (w_ir_load) begin
            r_ir <= imem_rdata;
         end
         if (w_exec) begin
            r_taken <= w_is_bne & neq;
         end
      end
   end

   // Architectural state committed only at retirement.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc       <= 8'h00;
         r_insn_cnt <= 16'h0000;
      end else if (w_retire) begin
         r_pc       <= w_pc_next;
         r_insn_cnt <= w_cnt_next;
      end
   end

   assign imem_req  = (r_state == ST_FETCH);
   assign imem_addr = r_pc;
   assign busy      = (r_state != ST_IDLE);
   assign bne       = w_is_bne & ((r_state == ST_DECODE) | (r_state == ST_EXEC) |
                                  (r_state == ST_WB));
   assign wb_strobe = (r_state == ST_WB) & ~w_is_bne;
   assign alu_op    = r_ir[7:6];
   assign rd        = r_ir[5:4];
   assign rs        = r_ir[3:2];
   assign rt        = r_ir[1:0];
   assign imm       = sext4(r_ir[3:0]);
   assign pc        = r_pc;
   assign insn_cnt  = r_insn_cnt;

endmodule
